// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with run-time loadable pattern, overlap select,
// valid-qualified input and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned       PAT_W       = 4,
  parameter logic [PAT_W-1:0]  DEFAULT_PAT = 4'b1101,
  parameter int unsigned       CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int unsigned FW = $clog2(PAT_W + 1);

  typedef enum logic [0:0] {FILL, ARMED} state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pattern, pattern_n;
  logic [PAT_W-1:0] history, history_n;
  logic [FW-1:0]    fill, fill_n;
  logic [CNT_W-1:0] cnt_n;
  logic             match_n;
  logic             consume;
  logic             hit;
  logic [PAT_W-1:0] shifted;
  logic [FW-1:0]    fill_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      pattern   <= DEFAULT_PAT;
      history   <= '0;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      state     <= state_n;
      pattern   <= pattern_n;
      history   <= history_n;
      fill      <= fill_n;
      match     <= match_n;
      match_cnt <= cnt_n;
    end
  end

  assign armed = (state == ARMED);

  always_comb begin
    pattern_n = pattern;
    history_n = history;
    fill_n    = fill;
    state_n   = state;
    match_n   = 1'b0;
    cnt_n     = match_cnt;
    consume   = in_valid && !pat_load;
    shifted   = {history[PAT_W-2:0], in};
    fill_inc  = fill + FW'(1);
    hit       = 1'b0;

    // A fill/state pair that cannot arise normally restarts the history.
    case (state)
      FILL: begin
        if (fill >= FW'(PAT_W)) begin
          fill_n  = '0;
          consume = 1'b0;
        end else begin
          hit = consume && (shifted == pattern) && (fill == FW'(PAT_W - 1));
        end
      end
      ARMED: begin
        if (fill != FW'(PAT_W)) begin
          state_n = FILL;
          fill_n  = '0;
          consume = 1'b0;
        end else begin
          hit = consume && (shifted == pattern);
        end
      end
      default: begin
        state_n = FILL;
        fill_n  = '0;
        consume = 1'b0;
      end
    endcase

    if (pat_load) begin
      pattern_n = pat_in;
      history_n = '0;
      fill_n    = '0;
      state_n   = FILL;
    end else if (consume) begin
      history_n = shifted;
      if (state == FILL) begin
        fill_n = fill_inc;
        if (fill_inc == FW'(PAT_W)) state_n = ARMED;
      end
      if (hit && !overlap_en) begin
        fill_n  = '0;
        state_n = FILL;
      end
    end

    match_n = hit;

    if (cnt_clr)
      cnt_n = hit ? CNT_W'(1) : '0;
    else if (hit && (match_cnt != '1))
      cnt_n = match_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a 2-bit counter
// instance driven by the same stimulus.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in, pat_load, overlap_en, cnt_clr;
  logic [3:0] pat_in;
  logic       match, armed, match2, armed2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .DEFAULT_PAT(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .match(match), .match_cnt(match_cnt), .armed(armed)
  );

  seq_detect_param #(.PAT_W(4), .DEFAULT_PAT(4'b1101), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(match_cnt2), .armed(armed2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in       = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Loads a pattern with a live bit on the same edge to exercise priority.
  task automatic load(input logic [3:0] p, input logic clr);
    pat_load = 1'b1;
    pat_in   = p;
    cnt_clr  = clr;
    in_valid = 1'b1;
    in       = 1'b1;
    @(posedge clk); #1;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] s1;
    logic [6:0] m1;
    logic [7:0] s2;
    logic [7:0] m2;
    logic [3:0] s4;
    rst = 1'b1; in_valid = 1'b0; in = 1'b0; pat_load = 1'b0;
    pat_in = 4'b0000; overlap_en = 1'b1; cnt_clr = 1'b0;
    #12 rst = 1'b0;

    chk("reset_match", {31'd0, match}, 32'd0);
    chk("reset_cnt", {24'd0, match_cnt}, 32'd0);
    chk("reset_armed", {31'd0, armed}, 32'd0);

    // 1: overlapping, stream 1101101
    s1 = 7'b1101101; m1 = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      send(s1[i]);
      chk("t1_match", {31'd0, match}, {31'd0, m1[i]});
      chk("t1_armed", {31'd0, armed}, (i <= 3) ? 32'd1 : 32'd0);
    end
    chk("t1_cnt", {24'd0, match_cnt}, 32'd2);

    // 2: non-overlapping, stream 11011011
    overlap_en = 1'b0;
    load(4'b1101, 1'b1);
    chk("t2_load_cnt", {24'd0, match_cnt}, 32'd0);
    chk("t2_load_armed", {31'd0, armed}, 32'd0);
    s2 = 8'b11011011; m2 = 8'b00010000;
    for (int i = 7; i >= 0; i--) begin
      send(s2[i]);
      chk("t2_match", {31'd0, match}, {31'd0, m2[i]});
    end
    chk("t2_cnt", {24'd0, match_cnt}, 32'd1);
    chk("t2_armed", {31'd0, armed}, 32'd1);

    // 3: pattern 1111, overlap then non-overlap
    overlap_en = 1'b1;
    load(4'b1111, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      send(1'b1);
      chk("t3a_match", {31'd0, match}, (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("t3a_cnt", {24'd0, match_cnt}, 32'd3);
    overlap_en = 1'b0;
    load(4'b1111, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      send(1'b1);
      chk("t3b_match", {31'd0, match}, (i == 4 || i == 8) ? 32'd1 : 32'd0);
    end
    chk("t3b_cnt", {24'd0, match_cnt}, 32'd2);

    // 4: gaps of 3 idle cycles between bits
    overlap_en = 1'b1;
    load(4'b1101, 1'b1);
    s4 = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      send(s4[i]);
      chk("t4_match", {31'd0, match}, (i == 0) ? 32'd1 : 32'd0);
      for (int g = 0; g < 3; g++) begin
        idle();
        chk("t4_gap", {31'd0, match}, 32'd0);
      end
    end
    chk("t4_cnt", {24'd0, match_cnt}, 32'd1);

    // 5: 2-bit counter saturation and clear
    load(4'b1111, 1'b1);
    for (int i = 1; i <= 8; i++) send(1'b1);
    chk("t5_sat", {30'd0, match_cnt2}, 32'd3);
    chk("t5_cnt8", {24'd0, match_cnt}, 32'd5);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    chk("t5_clr_match", {30'd0, match_cnt2}, 32'd1);
    chk("t5_clr_match8", {24'd0, match_cnt}, 32'd1);
    cnt_clr = 1'b1;
    idle();
    cnt_clr = 1'b0;
    chk("t5_clr_only", {30'd0, match_cnt2}, 32'd0);

    // 6: async reset mid-stream
    load(4'b1101, 1'b1);
    send(1'b1); send(1'b1); send(1'b0); send(1'b1);
    send(1'b1); send(1'b1); send(1'b0);
    chk("t6_pre_armed", {31'd0, armed}, 32'd1);
    chk("t6_pre_cnt", {24'd0, match_cnt}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cnt", {24'd0, match_cnt}, 32'd0);
    chk("t6_rst_armed", {31'd0, armed}, 32'd0);
    chk("t6_rst_match", {31'd0, match}, 32'd0);
    #2 rst = 1'b0;
    send(1'b1);
    chk("t6_straddle", {31'd0, match}, 32'd0);
    chk("t6_straddle_armed", {31'd0, armed}, 32'd0);
    send(1'b1); send(1'b1); send(1'b0);
    chk("t6_pre_match", {31'd0, match}, 32'd0);
    send(1'b1);
    chk("t6_match", {31'd0, match}, 32'd1);
    chk("t6_cnt", {24'd0, match_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector, successor to the fixed 4-bit "1101" detector.
- Pattern width is a parameter; the pattern itself is loadable at run time.
- Overlapping or non-overlapping detection is selected at run time.
- Input bits are qualified by a valid strobe, so gaps between bits are allowed.
- A saturating match counter is provided for status readback.
- Sits between a serial bit source (UART/line decoder) and control/status logic.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..32.
DEFAULT_PAT, 4'b1101 (PAT_W bits), pattern loaded on reset.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  qualifies in; bit is consumed on a clk edge with in_valid=1.
in  input  1  serial data bit.
pat_load  input  1  on an edge with pat_load=1, the pattern register takes pat_in.
pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit expected on the line.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
cnt_clr  input  1  synchronous clear of match_cnt.
match  output  1  registered one-cycle pulse; high in the cycle after the pattern-completing bit.
match_cnt  output  CNT_W  number of matches since reset or clear; saturates at all-ones.
armed  output  1  high when PAT_W valid bits are held in the history (state ARMED).

Behaviour:
- Reset (async, rst=1), applied immediately regardless of clk:
  - pattern <= DEFAULT_PAT; history <= 0; fill <= 0; state <= FILL.
  - match <= 0; match_cnt <= 0; armed <= 0.
- History register:
  - PAT_W-bit shift register: on each consumed bit, history <= {history[PAT_W-2:0], in}.
  - The oldest bit is at [PAT_W-1].
  - fill counts consumed bits since the last restart and saturates at PAT_W.
  - Counter width is clog2(PAT_W+1).
- State machine, two states:
  - FILL: fill < PAT_W. A consumed bit increments fill; goes to ARMED when fill reaches PAT_W.
  - ARMED: fill == PAT_W; armed=1. Every consumed bit is compared.
- Match condition:
  - Evaluated at the edge where a bit is consumed: {history[PAT_W-2:0], in} == pattern, and (state==ARMED, or fill==PAT_W-1 in FILL).
  - match is registered: 1 for the single cycle after that edge. Any edge without a match (including in_valid=0) drives match=0.
  - Latency from completing bit to match: 1 clk.
- Overlap rule:
  - overlap_en=1: history and fill are kept after a match, so bits of one match may start the next.
  - overlap_en=0: on a match, fill <= 0 and state <= FILL; the next match needs PAT_W fresh bits.
  - overlap_en is sampled on the match edge only.
- in_valid=0: history, fill and state hold; match=0. Gaps inside a pattern are transparent.
- pat_load=1:
  - pattern <= pat_in; history <= 0; fill <= 0; state <= FILL; match <= 0.
  - in/in_valid on that edge are ignored.
  - pat_load has priority over a bit consumed on the same edge.
- match_cnt:
  - Increments by 1 on each match edge; holds at 2^CNT_W-1.
  - cnt_clr alone: match_cnt <= 0.
  - cnt_clr together with a match on the same edge: match_cnt <= 1, so the event is not lost.
- Reset asserted mid-pattern discards the partial history; no match is produced for bits straddling reset.
- No X propagation: all registers are reset; there is no illegal state. An unreachable encoding returns to FILL with fill=0.

Test Plan:
1. Reset, defaults (1101), overlap_en=1; stream 1,1,0,1,1,0,1 with in_valid=1 every cycle -> match pulses one cycle after bits 4 and 7; match_cnt=2; armed=1 from after bit 4.
2. Same stream, overlap_en=0 -> match only after bit 4; bits 5..7 (1,0,1) give no match; append 1 -> still no match (1,0,1,1); match_cnt=1.
3. pat_load with pat_in=4'b1111; stream six 1s -> overlap_en=1: matches after bits 4,5,6 (cnt=3); overlap_en=0: match after bit 4 only, then next match after bit 8 when streaming 8 ones.
4. Stream 1,1,0,1 with in_valid deasserted 3 cycles between each bit -> exactly one match pulse, one cycle after the final bit's edge; match=0 during all gap cycles.
5. Counter: CNT_W=2, 5 matches -> match_cnt saturates at 3; assert cnt_clr on the same edge as the 6th match -> match_cnt=1; cnt_clr alone -> 0.
6. Send 1,1,0, then assert rst asynchronously between edges -> outputs go to 0 immediately; then send 1 -> no match; then full 1,1,0,1 -> match.
